// File: rtl/jtsdram_sched_pkg.sv
// Shared constants and state encodings for the SDRAM bank-checker scheduler.
package jtsdram_sched_pkg;
  localparam int NBANK = 4;
  localparam int AW    = 22;
  localparam int SAW   = 24;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_REPORT} test_st_t;
  typedef enum logic [1:0] {A_IDLE, A_ACK, A_RDY} arb_st_t;
endpackage

// File: rtl/jtsdram_sched_if.sv
// Checker-array and SDRAM read-port signals; master = scheduler, slave = environment.
interface jtsdram_sched_if;
  import jtsdram_sched_pkg::*;

  logic                      chk_lvbl;
  logic [NBANK-1:0]          chk_start;
  logic [NBANK-1:0][AW-1:0]  chk_addr;
  logic [NBANK-1:0]          chk_rd;
  logic [NBANK-1:0]          chk_ack;
  logic [NBANK-1:0]          chk_rdy;
  logic [31:0]               chk_data;
  logic [NBANK-1:0]          chk_done;
  logic [NBANK-1:0]          chk_bad;
  logic [SAW-1:0]            sdram_addr;
  logic                      sdram_rd;
  logic                      sdram_ack;
  logic                      sdram_rdy;
  logic [31:0]               sdram_dout;

  modport master (
    output chk_lvbl, chk_start, chk_ack, chk_rdy, chk_data, sdram_addr, sdram_rd,
    input  chk_addr, chk_rd, chk_done, chk_bad, sdram_ack, sdram_rdy, sdram_dout
  );
  modport slave (
    input  chk_lvbl, chk_start, chk_ack, chk_rdy, chk_data, sdram_addr, sdram_rd,
    output chk_addr, chk_rd, chk_done, chk_bad, sdram_ack, sdram_rdy, sdram_dout
  );
endinterface

// File: rtl/jtsdram_sched_rr_arb.sv
// Combinational round-robin picker: first request strictly after i_ptr, wrapping to i_ptr last.
module jtsdram_sched_rr_arb
  import jtsdram_sched_pkg::*;
(
  input  logic [NBANK-1:0] i_req,
  input  logic [1:0]       i_ptr,
  output logic             o_gnt_vld,
  output logic [1:0]       o_gnt
);
  // Scan far-to-near so the nearest requester after the pointer wins.
  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt     = i_ptr;
    for (int i = NBANK; i >= 1; i--) begin
      if (i_req[i_ptr + 2'(i)]) begin
        o_gnt_vld = 1'b1;
        o_gnt     = i_ptr + 2'(i);
      end
    end
  end
endmodule

// File: rtl/jtsdram_sched.sv
// Test scheduler: starts four bank checkers, shares the SDRAM read port round-robin,
// and folds done/bad/watchdog into per-run results and a saturating pass counter.
module jtsdram_sched
  import jtsdram_sched_pkg::*;
#(
  parameter int TOUTW = 10,
  parameter int PASSW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             LVBL,
  input  logic             go,
  input  logic             loop,
  jtsdram_sched_if.master  bus,
  output logic             busy,
  output logic [NBANK-1:0] bad_banks,
  output logic             timeout,
  output logic [PASSW-1:0] pass_cnt
);
  localparam logic [TOUTW-1:0] WD_ONES = '1;
  localparam logic [TOUTW-1:0] WD_LAST = WD_ONES - 1'b1;
  localparam logic [PASSW-1:0] PASS_MAX = '1;

  test_st_t       r_st;
  arb_st_t        r_arb;
  logic [1:0]     r_g, r_ptr;
  logic [TOUTW-1:0] r_wd;
  logic           r_start, r_run_bad, r_run_to, r_rd;
  logic [SAW-1:0] r_addr;
  logic           w_gnt_vld, w_wd_fire;
  logic [1:0]     w_gnt;

  jtsdram_sched_rr_arb u_arb (
    .i_req     (bus.chk_rd),
    .i_ptr     (r_ptr),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt     (w_gnt)
  );

  // Fires on the cycle the stall counter would reach all-ones without progress.
  assign w_wd_fire = ((r_arb == A_ACK && !bus.sdram_ack) ||
                      (r_arb == A_RDY && !bus.sdram_rdy)) && (r_wd == WD_LAST);

  assign bus.sdram_rd   = r_rd;
  assign bus.sdram_addr = r_addr;
  assign bus.chk_start  = {NBANK{r_start}};
  assign bus.chk_ack    = (r_arb == A_ACK && bus.sdram_ack) ? (NBANK'(1) << r_g) : '0;
  assign bus.chk_rdy    = (r_arb == A_RDY && bus.sdram_rdy) ? (NBANK'(1) << r_g) : '0;
  assign bus.chk_data   = bus.sdram_dout;
  // Keep checkers awake while a transaction is still in flight during blanking.
  assign bus.chk_lvbl   = rst_n & (LVBL | (r_arb != A_IDLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arb  <= A_IDLE;
      r_g    <= '0;
      r_ptr  <= '0;
      r_wd   <= '0;
      r_rd   <= 1'b0;
      r_addr <= '0;
    end else begin
      case (r_arb)
        A_IDLE: if (r_st == S_RUN && LVBL && w_gnt_vld) begin
          r_g    <= w_gnt;
          r_addr <= {w_gnt, bus.chk_addr[w_gnt]};
          r_rd   <= 1'b1;
          r_arb  <= A_ACK;
          r_wd   <= '0;
        end
        A_ACK: begin
          if (bus.sdram_ack) begin
            r_rd  <= 1'b0;
            r_arb <= A_RDY;
            r_wd  <= '0;
          end else if (w_wd_fire) begin
            r_rd  <= 1'b0;
            r_arb <= A_IDLE;
            r_wd  <= '0;
          end else r_wd <= r_wd + 1'b1;
        end
        A_RDY: begin
          if (bus.sdram_rdy) begin
            r_ptr <= r_g;
            r_arb <= A_IDLE;
            r_wd  <= '0;
          end else if (w_wd_fire) begin
            r_arb <= A_IDLE;
            r_wd  <= '0;
          end else r_wd <= r_wd + 1'b1;
        end
        default: r_arb <= A_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st      <= S_IDLE;
      r_start   <= 1'b0;
      r_run_bad <= 1'b0;
      r_run_to  <= 1'b0;
      busy      <= 1'b0;
      bad_banks <= '0;
      timeout   <= 1'b0;
      pass_cnt  <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_st)
        S_IDLE: if (go) begin
          bad_banks <= '0;
          timeout   <= 1'b0;
          pass_cnt  <= '0;
          busy      <= 1'b1;
          r_start   <= 1'b1;
          r_st      <= S_START;
        end
        S_START: begin
          r_run_bad <= 1'b0;
          r_run_to  <= 1'b0;
          r_st      <= S_RUN;
        end
        S_RUN: begin
          bad_banks <= bad_banks | bus.chk_bad;
          r_run_bad <= r_run_bad | (|bus.chk_bad);
          if (w_wd_fire) begin
            timeout  <= 1'b1;
            r_run_to <= 1'b1;
            r_st     <= S_REPORT;
          end else if (&bus.chk_done) r_st <= S_REPORT;
        end
        S_REPORT: begin
          if (!r_run_bad && !r_run_to && pass_cnt != PASS_MAX) pass_cnt <= pass_cnt + 1'b1;
          if (loop) begin
            r_start <= 1'b1;
            r_st    <= S_START;
          end else begin
            busy <= 1'b0;
            r_st <= S_IDLE;
          end
        end
        default: r_st <= S_IDLE;
      endcase
      // A straggling transaction may still time out after its run ended.
      if (w_wd_fire && r_st != S_RUN && !(r_st == S_IDLE && go)) timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_jtsdram_sched.sv
// Directed + randomized bench for jtsdram_sched with a protocol-level grant/handshake model.
module tb_jtsdram_sched;
  import jtsdram_sched_pkg::*;
  localparam int TOUTW = 4;
  localparam int PASSW = 2;

  logic clk = 1'b0, rst_n = 1'b0, LVBL = 1'b1, go = 1'b0, loop = 1'b0;
  logic busy, timeout;
  logic [NBANK-1:0] bad_banks;
  logic [PASSW-1:0] pass_cnt;

  jtsdram_sched_if bus();

  jtsdram_sched #(.TOUTW(TOUTW), .PASSW(PASSW)) dut (
    .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .go(go), .loop(loop), .bus(bus),
    .busy(busy), .bad_banks(bad_banks), .timeout(timeout), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0;
  int ack_dly = 2, rdy_dly = 4;
  bit never_ack = 1'b0;
  int m_phase = 0, m_ptr = 0, m_g = 0, n_grant = 0, eg;
  int glog[$];
  logic [NBANK-1:0] prev_req = '0, ea, er;
  logic prev_lvbl = 1'b0;
  logic [NBANK-1:0][AW-1:0] prev_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NBANK-1:0] req, input int ptr);
    for (int i = 1; i <= NBANK; i++) if (req[(ptr + i) % NBANK]) return (ptr + i) % NBANK;
    return -1;
  endfunction

  // Controller model: ack ack_dly cycles after seeing a request, data rdy_dly cycles after ack.
  initial begin
    bus.sdram_ack = 1'b0; bus.sdram_rdy = 1'b0; bus.sdram_dout = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && bus.sdram_rd && !never_ack) begin
        repeat (ack_dly - 1) begin @(posedge clk); #1; end
        bus.sdram_ack = 1'b1;
        @(posedge clk); #1;
        bus.sdram_ack = 1'b0;
        repeat (rdy_dly - 1) begin @(posedge clk); #1; end
        bus.sdram_rdy = 1'b1; bus.sdram_dout = $urandom;
        @(posedge clk); #1;
        bus.sdram_rdy = 1'b0;
      end
    end
  end

  // Monitor: checks each grant against round-robin rules and each ack/rdy pulse against the grant.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0;
    end else begin
      if (m_phase == 0 && bus.sdram_rd) begin
        eg = rr_pick(prev_req, m_ptr);
        chk("grant_bank", 64'(bus.sdram_addr[23:22]), 64'(eg));
        chk("grant_addr", 64'(bus.sdram_addr[21:0]), 64'(prev_addr[bus.sdram_addr[23:22]]));
        chk("grant_lvbl", 64'(prev_lvbl), 64'(1));
        m_g = int'(bus.sdram_addr[23:22]);
        glog.push_back(m_g);
        n_grant++;
        m_phase = 1;
      end else if (m_phase == 1 && !bus.sdram_rd) m_phase = 0;
      ea = (m_phase == 1 && bus.sdram_ack) ? NBANK'(1) << m_g : '0;
      er = (m_phase == 2 && bus.sdram_rdy) ? NBANK'(1) << m_g : '0;
      if (ea != '0 || bus.chk_ack != '0) chk("chk_ack", 64'(bus.chk_ack), 64'(ea));
      if (er != '0 || bus.chk_rdy != '0) chk("chk_rdy", 64'(bus.chk_rdy), 64'(er));
      if (er != '0) chk("chk_data", 64'(bus.chk_data), 64'(bus.sdram_dout));
      if (m_phase != 0) chk("chk_lvbl_busy", 64'(bus.chk_lvbl), 64'(1));
      if (m_phase == 1 && bus.sdram_ack) m_phase = 2;
      else if (m_phase == 2 && bus.sdram_rdy) begin m_phase = 0; m_ptr = m_g; end
    end
    prev_req  = bus.chk_rd;
    prev_addr = bus.chk_addr;
    prev_lvbl = LVBL;
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic pulse_go(); go = 1'b1; step(); go = 1'b0; endtask

  task automatic wait_rd(input int lim);
    for (int c = 0; c < lim && !bus.sdram_rd; c++) step();
    chk("wait_rd", 64'(bus.sdram_rd), 64'(1));
  endtask

  task automatic wait_start(input int lim);
    for (int c = 0; c < lim && bus.chk_start == '0; c++) step();
    chk("wait_start", 64'(bus.chk_start), 64'(4'hF));
  endtask

  task automatic wait_idle(input int lim);
    for (int c = 0; c < lim && busy; c++) step();
    chk("wait_idle", 64'(busy), 64'(0));
  endtask

  task automatic wait_grants(input int n, input int lim);
    int target;
    target = n_grant + n;
    for (int c = 0; c < lim && n_grant < target; c++) step();
    chk("wait_grants", 64'(n_grant >= target), 64'(1));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".sdram_rd"},   64'(bus.sdram_rd), 0);
    chk({tag, ".sdram_addr"}, 64'(bus.sdram_addr), 0);
    chk({tag, ".busy"},       64'(busy), 0);
    chk({tag, ".chk_start"},  64'(bus.chk_start), 0);
    chk({tag, ".chk_ack"},    64'(bus.chk_ack), 0);
    chk({tag, ".chk_rdy"},    64'(bus.chk_rdy), 0);
    chk({tag, ".chk_lvbl"},   64'(bus.chk_lvbl), 0);
    chk({tag, ".bad_banks"},  64'(bad_banks), 0);
    chk({tag, ".timeout"},    64'(timeout), 0);
    chk({tag, ".pass_cnt"},   64'(pass_cnt), 0);
  endtask

  initial begin
    int n, m_pass;
    bit seen_ack, seen_rdy;
    bus.chk_rd = '0; bus.chk_done = '0; bus.chk_bad = '0;
    for (int b = 0; b < NBANK; b++) bus.chk_addr[b] = AW'($urandom);
    repeat (3) step();
    check_zero("reset");
    rst_n = 1'b1; step();

    // Reset in the middle of a pending read.
    never_ack = 1'b1; bus.chk_rd = 4'hF;
    pulse_go();
    wait_rd(10);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    step(); step();
    rst_n = 1'b1; never_ack = 1'b0; bus.chk_rd = '0;
    repeat (3) step();

    // All banks requesting: rotation starts after bank 0.
    ack_dly = 2; rdy_dly = 4; glog.delete();
    bus.chk_rd = 4'hF;
    pulse_go();
    wait_grants(8, 200);
    for (int i = 0; i < 8; i++)
      chk($sformatf("order%0d", i), 64'(i < glog.size() ? glog[i] : -1), 64'((i + 1) % NBANK));
    for (int s = 0; s < 4; s++) begin
      bus.chk_rd = NBANK'($urandom_range(1, 15));
      ack_dly = $urandom_range(1, 3); rdy_dly = $urandom_range(1, 5);
      for (int b = 0; b < NBANK; b++) bus.chk_addr[b] = AW'($urandom);
      wait_grants(6, 300);
    end
    bus.chk_rd = '0;
    repeat (20) step();
    bus.chk_done = 4'hF;
    wait_idle(10);
    bus.chk_done = '0;
    chk("run2_pass", 64'(pass_cnt), 1);
    chk("run2_bad", 64'(bad_banks), 0);
    chk("run2_to", 64'(timeout), 0);

    // Blanking starts one cycle into a transaction.
    ack_dly = 3; rdy_dly = 3; bus.chk_rd = 4'b0010;
    pulse_go();
    chk("go_clears_pass", 64'(pass_cnt), 0);
    wait_rd(20);
    step(); LVBL = 1'b0;
    seen_ack = 1'b0; seen_rdy = 1'b0;
    for (int c = 0; c < 30 && !seen_rdy; c++) begin
      @(negedge clk);
      if (!seen_ack) chk("lvbl_rd_hold", 64'(bus.sdram_rd), 1);
      chk("lvbl_chk_lvbl", 64'(bus.chk_lvbl), 1);
      if (bus.sdram_ack) seen_ack = 1'b1;
      if (bus.sdram_rdy) seen_rdy = 1'b1;
    end
    chk("lvbl_rdy_seen", 64'(seen_rdy), 1);
    repeat (10) begin
      @(negedge clk);
      chk("blank_no_grant", 64'(bus.sdram_rd), 0);
      chk("blank_chk_lvbl", 64'(bus.chk_lvbl), 0);
    end
    step(); LVBL = 1'b1;
    wait_rd(5);
    bus.chk_rd = '0;
    repeat (15) step();

    // A failing bank with looping enabled.
    loop = 1'b1; bus.chk_bad = 4'b0100; bus.chk_done = 4'hF;
    wait_start(10);
    bus.chk_done = '0; bus.chk_bad = '0;
    chk("bad_pass", 64'(pass_cnt), 0);
    chk("bad_banks", 64'(bad_banks), 64'(4'b0100));
    chk("bad_busy", 64'(busy), 1);

    // Clean looping runs; the 2-bit counter saturates.
    m_pass = 0;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(1, 5)) step();
      bus.chk_done = 4'hF;
      wait_start(10);
      bus.chk_done = '0;
      m_pass = (m_pass < (1 << PASSW) - 1) ? m_pass + 1 : m_pass;
      chk($sformatf("pass%0d", k), 64'(pass_cnt), 64'(m_pass));
      chk($sformatf("sticky_bad%0d", k), 64'(bad_banks), 64'(4'b0100));
    end
    loop = 1'b0;
    repeat (2) step();
    bus.chk_done = 4'hF;
    wait_idle(10);
    bus.chk_done = '0;
    chk("pass_sat", 64'(pass_cnt), 64'((1 << PASSW) - 1));

    // Controller never acks: watchdog ends the run.
    never_ack = 1'b1; bus.chk_rd = 4'b1000;
    pulse_go();
    chk("to_go_pass", 64'(pass_cnt), 0);
    chk("to_go_bad", 64'(bad_banks), 0);
    chk("to_go_start", 64'(bus.chk_start), 64'(4'hF));
    wait_rd(10);
    n = 0;
    for (int c = 0; c < 40 && bus.sdram_rd; c++) begin n++; step(); end
    chk("to_cycles", 64'(n), 64'((1 << TOUTW) - 1));
    chk("to_flag", 64'(timeout), 1);
    chk("to_rd_drop", 64'(bus.sdram_rd), 0);
    chk("to_report_busy", 64'(busy), 1);
    bus.chk_rd = '0;
    step();
    chk("to_idle_busy", 64'(busy), 0);
    chk("to_sticky", 64'(timeout), 1);
    chk("to_pass", 64'(pass_cnt), 0);
    never_ack = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: observed running expected finished");
    $fatal(1, "time limit");
  end
endmodule
